// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified-memory port arbiter: default widths,
// timeout limit and FSM state encodings.
package mem_port_arbiter_pkg;

   localparam int MEM_ADDR_W  = 10;
   localparam int MEM_DATA_W  = 32;
   localparam int MEM_TIMEOUT = 64;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUSY_I = 2'd1;
   localparam logic [1:0] S_BUSY_D = 2'd2;

   function automatic logic isBusy(input logic [1:0] s);
      return (s == S_BUSY_I) || (s == S_BUSY_D);
   endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Saturating count of stalled BUSY cycles; raises a sticky err at the end of
// the TIMEOUT-th consecutive BUSY cycle without mem_rdy.
import mem_port_arbiter_pkg::*;

module mem_arb_timeout #(
   parameter int TIMEOUT = MEM_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic busy,
   input  logic rdy,
   output logic err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt;
   logic             stalled;

   assign stalled = busy && !rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (clear)
            cnt <= '0;
         else if (stalled && cnt != LIMIT)
            cnt <= cnt + 1'b1;
         // err lands on the same edge the counter reaches the limit
         if (stalled && cnt >= LIMIT - 1'b1)
            err <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants a single-port unified memory to the fetch or data port, data first,
// alternating directly between ports on completion so neither starves.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W,
   parameter int TIMEOUT = MEM_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rdy,
   output logic              err
);

   logic [1:0] state, stateNext;
   logic       busy, done, grantD, grantI;

   assign busy = isBusy(state);
   assign done = busy && mem_rdy;

   // The port just served is excluded from the completion decision.
   always_comb begin
      grantD    = 1'b0;
      grantI    = 1'b0;
      stateNext = state;
      case (state)
         S_IDLE: begin
            if (d_req)       grantD = 1'b1;
            else if (if_req) grantI = 1'b1;
         end
         S_BUSY_I: if (mem_rdy && d_req)  grantD = 1'b1;
         S_BUSY_D: if (mem_rdy && if_req) grantI = 1'b1;
         default:  ;
      endcase
      if (grantD)      stateNext = S_BUSY_D;
      else if (grantI) stateNext = S_BUSY_I;
      else if (done || !(busy || state == S_IDLE)) stateNext = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state <= stateNext;
         if (grantD) begin
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
         end else if (grantI) begin
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
         end
      end
   end

   assign mem_req = busy;

   // A request dropped mid-transaction still completes but is never acked.
   assign if_ack   = (state == S_BUSY_I) && mem_rdy && if_req;
   assign d_ack    = (state == S_BUSY_D) && mem_rdy && d_req;
   assign if_rdata = if_ack ? mem_rdata : '0;
   assign d_rdata  = d_ack  ? mem_rdata : '0;

   assign stall_if  = if_req && !if_ack;
   assign stall_mem = d_req && !d_ack;

   mem_arb_timeout #(.TIMEOUT(TIMEOUT)) uTimeout (
      .clk   (clk),
      .rst   (rst),
      .clear (grantD || grantI),
      .busy  (busy),
      .rdy   (mem_rdy),
      .err   (err)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a variable-latency memory model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [9:0]  if_addr, d_addr;
   logic [31:0] d_wdata;
   logic        if_ack, d_ack, stall_if, stall_mem;
   logic [31:0] if_rdata, d_rdata;
   logic        mem_req, mem_we, mem_rdy, err;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int nChk = 0;
   int nFail = 0;

   // memory model: ready lat cycles after mem_req rises (or when forced)
   int          lat = 1;
   int          waitCnt = 0;
   logic        forceRdy = 1'b0;
   logic        memClr = 1'b1;
   logic [31:0] memArr [0:1023];
   logic [1023:0] wrValid;

   assign mem_rdy   = mem_req && (forceRdy || waitCnt == lat);
   assign mem_rdata = wrValid[mem_addr] ? memArr[mem_addr] : (32'hC0DE0000 | 32'(mem_addr));

   always @(posedge clk) begin
      if (!mem_req || mem_rdy) waitCnt <= 0;
      else                     waitCnt <= waitCnt + 1;
      if (memClr) wrValid <= '0;
      else if (mem_rdy && mem_we) begin
         memArr[mem_addr]  <= mem_wdata;
         wrValid[mem_addr] <= 1'b1;
      end
   end

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .err(err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChk++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; if_req = 0; d_req = 0; d_we = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      #3;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_err", err, 0);
      if_req = 1; d_req = 1;
      #1;
      chk("rst_stall_if", stall_if, 1);
      chk("rst_stall_mem", stall_mem, 1);
      chk("rst_acks", {if_ack, d_ack}, 0);
      chk("rst_rdata", {if_rdata, d_rdata}, 0);
      if_req = 0; d_req = 0;
      step; step;
      memClr = 1'b0; rst = 1'b1;
      step;

      // lone fetch, memory ready one cycle after mem_req
      if_req = 1; if_addr = 10'h004;
      #1;
      chk("f_stall_c0", stall_if, 1);
      chk("f_idle_req", mem_req, 0);
      step;
      chk("f_mem_req", mem_req, 1);
      chk("f_mem_addr", mem_addr, 10'h004);
      chk("f_mem_we", mem_we, 0);
      chk("f_no_ack_c1", if_ack, 0);
      chk("f_stall_c1", stall_if, 1);
      step;
      chk("f_ack_c2", if_ack, 1);
      chk("f_rdata", if_rdata, 32'hC0DE0004);
      chk("f_stall_c2", stall_if, 0);
      if_req = 0;
      step;
      chk("f_idle_after", mem_req, 0);

      // simultaneous store and fetch: data first, then fetch with no bubble
      d_req = 1; d_we = 1; d_addr = 10'h010; d_wdata = 32'hDEADBEEF;
      if_req = 1; if_addr = 10'h008;
      step;
      chk("s_mem_we", mem_we, 1);
      chk("s_mem_addr", mem_addr, 10'h010);
      chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("s_acks_c1", {d_ack, if_ack}, 2'b00);
      step;
      chk("s_acks_c2", {d_ack, if_ack}, 2'b10);
      chk("s_stall_if", stall_if, 1);
      d_req = 0; d_we = 0;
      step;
      chk("s_fetch_req", mem_req, 1);
      chk("s_fetch_addr", mem_addr, 10'h008);
      chk("s_fetch_we", mem_we, 0);
      chk("s_fetch_noack", if_ack, 0);
      step;
      chk("s_fetch_ack", if_ack, 1);
      chk("s_fetch_rdata", if_rdata, 32'hC0DE0008);
      if_req = 0;
      step;
      chk("s_idle", mem_req, 0);

      // load back with latency 3: ack four cycles after req
      lat = 3; d_req = 1; d_we = 0; d_addr = 10'h010;
      for (int c = 1; c <= 4; c++) begin
         step;
         chk("l_addr_stable", mem_addr, 10'h010);
         chk("l_ack", d_ack, (c == 4) ? 1 : 0);
      end
      chk("l_rdata", d_rdata, 32'hDEADBEEF);
      d_req = 0;
      step;
      chk("l_idle", mem_req, 0);

      // both ports continuously requesting: strict D,I alternation
      lat = 1; d_req = 1; d_we = 0; d_addr = 10'h020; if_req = 1; if_addr = 10'h030;
      begin
         int n = 0;
         int guard = 0;
         while (n < 20 && guard < 200) begin
            step;
            guard++;
            if (d_ack || if_ack) begin
               chk("alt_order", {d_ack, if_ack}, (n % 2 == 0) ? 2'b10 : 2'b01);
               chk("alt_addr", mem_addr, (n % 2 == 0) ? 10'h020 : 10'h030);
               n++;
            end
         end
         chk("alt_count", n, 20);
      end
      d_req = 0; if_req = 0;
      step;
      chk("alt_idle", mem_req, 0);

      // timeout: memory never ready until forced
      lat = 100000; d_req = 1; d_we = 0; d_addr = 10'h010;
      for (int c = 1; c <= 70; c++) begin
         step;
         if (c == 64) chk("to_err_c64", err, 0);
         if (c == 65) chk("to_err_c65", err, 1);
      end
      chk("to_err_c70", err, 1);
      chk("to_still_busy", mem_req, 1);
      forceRdy = 1'b1;
      #1;
      chk("to_late_ack", d_ack, 1);
      chk("to_late_rdata", d_rdata, 32'hDEADBEEF);
      d_req = 0;
      step;
      forceRdy = 1'b0; lat = 3;
      chk("to_idle", mem_req, 0);
      chk("to_err_sticky", err, 1);

      // reset mid BUSY_D with fetch pending
      d_req = 1; d_we = 1; d_addr = 10'h040; d_wdata = 32'h12345678;
      if_req = 1; if_addr = 10'h00C;
      step; step;
      chk("r_busy", mem_req, 1);
      chk("r_busy_we", mem_we, 1);
      rst = 1'b0;
      #1;
      chk("r_async_req", mem_req, 0);
      chk("r_no_ack", d_ack, 0);
      chk("r_err_clr", err, 0);
      d_req = 0; d_we = 0; lat = 1;
      @(negedge clk);
      rst = 1'b1;
      step;
      chk("r_grant_i", mem_req, 1);
      chk("r_grant_addr", mem_addr, 10'h00C);
      chk("r_grant_we", mem_we, 0);
      chk("r_no_write", wrValid[10'h040], 0);
      step;
      chk("r_if_ack", if_ack, 1);
      chk("r_if_rdata", if_rdata, 32'hC0DE000C);
      if_req = 0;
      step;

      $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
      $finish;
   end

endmodule
